// File: rtl/branch_redirect_unit.sv
// Carries branch predictions from D through E to M, resolves them in M and steers the fetch PC.
// Define BRU_STATS_EN to add saturating branch / misprediction counters with a clear input.
module branch_redirect_unit #(
  parameter int PC_W      = 32,
  parameter int DSLOT_OFS = 8
`ifdef BRU_STATS_EN
  ,
  parameter int STAT_W    = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallE,
  input  logic            stallM,
  input  logic            flushE,
  input  logic            flushM,
  input  logic            branchD,
  input  logic            pred_takeD,
  input  logic [PC_W-1:0] pcD,
  input  logic [PC_W-1:0] targetD,
  input  logic            cond_takeE,
`ifdef BRU_STATS_EN
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred,
`endif
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic [1:0]      pc_src,
  output logic            flushD_req,
  output logic            branchM,
  output logic            actual_takeM,
  output logic            errorM,
  output logic [PC_W-1:0] pcM
);

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } bruState_t;

  bruState_t       state;
  bruState_t       nextState;

  logic            validE;
  logic            predE;
  logic [PC_W-1:0] pcE;
  logic [PC_W-1:0] targetE;

  logic            validM;
  logic            predM;
  logic [PC_W-1:0] targetM;

  logic            reported;
  logic [PC_W-1:0] recoveryPc;
  logic            predTakenD;

  // D->E register; a flush bubble wins even while the stage is stalled
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      validE  <= 1'b0;
      predE   <= 1'b0;
      pcE     <= '0;
      targetE <= '0;
    end else if (!stallE) begin
      validE  <= branchD;
      predE   <= branchD & pred_takeD;
      pcE     <= pcD;
      targetE <= targetD;
    end
  end

  // E->M register; the branch direction is captured here once the condition is known
  always_ff @(posedge clk) begin
    if (rst || flushM) begin
      validM       <= 1'b0;
      predM        <= 1'b0;
      actual_takeM <= 1'b0;
      pcM          <= '0;
      targetM      <= '0;
    end else if (!stallM) begin
      validM       <= validE;
      predM        <= predE;
      actual_takeM <= validE & cond_takeE;
      pcM          <= pcE;
      targetM      <= targetE;
    end
  end

  assign branchM = validM;

  // Remembers that the branch parked in M has already raised its misprediction
  always_ff @(posedge clk) begin
    if (rst || flushM || !stallM) begin
      reported <= 1'b0;
    end else if (errorM) begin
      reported <= 1'b1;
    end
  end

  assign errorM = validM & (predM != actual_takeM) & ~reported & (state == NORMAL);

  assign recoveryPc = actual_takeM ? targetM : (pcM + PC_W'(DSLOT_OFS));

  // D-stage predictions are ignored while the instruction in D is known wrong-path
  assign predTakenD = branchD & pred_takeD & (state == NORMAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      NORMAL:  if (errorM) nextState = RECOVER;
      RECOVER: nextState = NORMAL;
      default: nextState = NORMAL;
    endcase
  end

  // M-stage recovery outranks a D-stage predicted-taken redirect
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    pc_src      = 2'b00;
    flushD_req  = 1'b0;
    if (errorM) begin
      redirect    = 1'b1;
      redirect_pc = recoveryPc;
      pc_src      = 2'b10;
      flushD_req  = 1'b1;
    end else if (predTakenD) begin
      redirect    = 1'b1;
      redirect_pc = targetD;
      pc_src      = 2'b01;
    end
    if (state == RECOVER) begin
      flushD_req = 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  // Counters stick at all-ones; a clear beats an increment in the same cycle
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (validM && !stallM && !(&stat_branches)) begin
        stat_branches <= stat_branches + 1'b1;
      end
      if (errorM && !(&stat_mispred)) begin
        stat_mispred <= stat_mispred + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed scenarios plus randomized traffic
// compared every cycle against a per-branch behavioural model (stats checked under BRU_STATS_EN).
module tb_branch_redirect_unit;

  logic        clk;
  logic        rst;
  logic        stallE, stallM, flushE, flushM;
  logic        branchD, pred_takeD, cond_takeE;
  logic [31:0] pcD, targetD;
  logic        redirect, flushD_req, branchM, actual_takeM, errorM;
  logic [31:0] redirect_pc, pcM;
  logic [1:0]  pc_src;
  logic        statClr;
`ifdef BRU_STATS_EN
  logic [3:0]  stat_branches, stat_mispred;
`endif

  int numChecks;
  int numFailures;

  branch_redirect_unit #(
    .PC_W(32),
    .DSLOT_OFS(8)
`ifdef BRU_STATS_EN
    ,
    .STAT_W(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallE(stallE),
    .stallM(stallM),
    .flushE(flushE),
    .flushM(flushM),
    .branchD(branchD),
    .pred_takeD(pred_takeD),
    .pcD(pcD),
    .targetD(targetD),
    .cond_takeE(cond_takeE),
`ifdef BRU_STATS_EN
    .stat_clr(statClr),
    .stat_branches(stat_branches),
    .stat_mispred(stat_mispred),
`endif
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .pc_src(pc_src),
    .flushD_req(flushD_req),
    .branchM(branchM),
    .actual_takeM(actual_takeM),
    .errorM(errorM),
    .pcM(pcM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One in-flight instruction slot; "reported" records whether this branch already flagged its mispredict
  typedef struct {
    logic        valid;
    logic        pred;
    logic        taken;
    logic        reported;
    logic [31:0] pc;
    logic [31:0] target;
  } slot_t;

  slot_t slotE, slotM;
  logic  recovering;
  int    modelBranches, modelMispred;

  function automatic slot_t emptySlot();
    slot_t s;
    s.valid = 1'b0; s.pred = 1'b0; s.taken = 1'b0; s.reported = 1'b0;
    s.pc = '0; s.target = '0;
    return s;
  endfunction

  function automatic logic modelError();
    return slotM.valid && (slotM.pred != slotM.taken) && !slotM.reported && !recovering;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFailures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every output against what the model says this cycle should produce
  task automatic checkModel();
    logic        expErr, expRedir, expFlushD;
    logic [1:0]  expSrc;
    logic [31:0] expPc;
    expErr    = modelError();
    expRedir  = 1'b0;
    expSrc    = 2'b00;
    expPc     = 32'h0;
    expFlushD = recovering;
    if (expErr) begin
      expRedir  = 1'b1;
      expSrc    = 2'b10;
      expPc     = slotM.taken ? slotM.target : slotM.pc + 32'd8;
      expFlushD = 1'b1;
    end else if (branchD && pred_takeD && !recovering) begin
      expRedir = 1'b1;
      expSrc   = 2'b01;
      expPc    = targetD;
    end
    checkOutput("redirect", 64'(redirect), 64'(expRedir));
    checkOutput("pc_src", 64'(pc_src), 64'(expSrc));
    checkOutput("redirect_pc", 64'(redirect_pc), 64'(expPc));
    checkOutput("flushD_req", 64'(flushD_req), 64'(expFlushD));
    checkOutput("branchM", 64'(branchM), 64'(slotM.valid));
    checkOutput("actual_takeM", 64'(actual_takeM), 64'(slotM.taken));
    checkOutput("errorM", 64'(errorM), 64'(expErr));
    checkOutput("pcM", 64'(pcM), 64'(slotM.pc));
`ifdef BRU_STATS_EN
    checkOutput("stat_branches", 64'(stat_branches), 64'(modelBranches));
    checkOutput("stat_mispred", 64'(stat_mispred), 64'(modelMispred));
`endif
  endtask

  // Drive one cycle of inputs and check the combinational response mid-cycle
  task automatic applyStimulus(input logic bD, input logic pT, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic cE, input logic sE,
                               input logic sM, input logic fE, input logic fM, input logic r);
    branchD = bD; pred_takeD = pT; pcD = pc; targetD = tgt; cond_takeE = cE;
    stallE = sE; stallM = sM; flushE = fE; flushM = fM; rst = r;
    @(negedge clk);
    checkModel();
  endtask

  // Advance the model across the clock edge, then let the DUT settle
  task automatic clockEdge();
    logic  err;
    slot_t nextM;
    err = modelError();
    @(posedge clk);
    if (rst) begin
      slotE = emptySlot(); slotM = emptySlot(); recovering = 1'b0;
      modelBranches = 0; modelMispred = 0;
    end else begin
      if (statClr) begin
        modelBranches = 0; modelMispred = 0;
      end else begin
        if (slotM.valid && !stallM && modelBranches < 15) modelBranches++;
        if (err && modelMispred < 15) modelMispred++;
      end
      nextM = slotM;
      if (flushM) nextM = emptySlot();
      else if (!stallM) begin
        nextM = slotE;
        nextM.taken = slotE.valid & cond_takeE;
        nextM.reported = 1'b0;
      end else if (err) nextM.reported = 1'b1;
      slotM = nextM;
      if (flushE) slotE = emptySlot();
      else if (!stallE) begin
        slotE.valid = branchD; slotE.pred = branchD & pred_takeD;
        slotE.pc = pcD; slotE.target = targetD; slotE.taken = 1'b0; slotE.reported = 1'b0;
      end
      recovering = err;
    end
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    clockEdge();
  endtask

  initial begin
    numChecks = 0; numFailures = 0; statClr = 1'b0;
    slotE = emptySlot(); slotM = emptySlot(); recovering = 1'b0;
    modelBranches = 0; modelMispred = 0;
    rst = 1'b1; branchD = 0; pred_takeD = 0; pcD = 0; targetD = 0; cond_takeE = 0;
    stallE = 0; stallM = 0; flushE = 0; flushM = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset state");
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst_redirect", 64'(redirect), 64'd0);
    checkOutput("rst_branchM", 64'(branchM), 64'd0);
    checkOutput("rst_flushD", 64'(flushD_req), 64'd0);
    clockEdge();

    $display("[TB] predicted taken from D");
    applyStimulus(1, 1, 32'h0040_0000, 32'h0040_0100, 0, 0, 0, 0, 0, 0);
    checkOutput("tp1_redirect", 64'(redirect), 64'd1);
    checkOutput("tp1_pc_src", 64'(pc_src), 64'd1);
    checkOutput("tp1_redirect_pc", 64'(redirect_pc), 64'h0040_0100);
    checkOutput("tp1_flushD", 64'(flushD_req), 64'd0);
    clockEdge();
    applyStimulus(0, 0, 32'h0040_0004, 32'h0, 1, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(0, 0, 32'h0040_0100, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp1_branchM", 64'(branchM), 64'd1);
    checkOutput("tp1_actual", 64'(actual_takeM), 64'd1);
    checkOutput("tp1_errorM", 64'(errorM), 64'd0);
    clockEdge();
    idleCycle();

    $display("[TB] mispredict not-taken but taken");
    applyStimulus(1, 0, 32'h0040_0020, 32'h0040_0200, 0, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(0, 0, 32'h0040_0024, 32'h0, 1, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(0, 0, 32'h0040_0028, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp2_errorM", 64'(errorM), 64'd1);
    checkOutput("tp2_redirect_pc", 64'(redirect_pc), 64'h0040_0200);
    checkOutput("tp2_pc_src", 64'(pc_src), 64'd2);
    checkOutput("tp2_flushD", 64'(flushD_req), 64'd1);
    clockEdge();
    applyStimulus(0, 0, 32'h0040_0200, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp2_recover_flushD", 64'(flushD_req), 64'd1);
    checkOutput("tp2_recover_errorM", 64'(errorM), 64'd0);
    clockEdge();
    idleCycle();

    $display("[TB] mispredict taken but not taken");
    applyStimulus(1, 1, 32'h0040_0020, 32'h0040_0200, 0, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(0, 0, 32'h0040_0200, 32'h0, 0, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(0, 0, 32'h0040_0204, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp3_errorM", 64'(errorM), 64'd1);
    checkOutput("tp3_redirect_pc", 64'(redirect_pc), 64'h0040_0028);
    clockEdge();
    idleCycle();

    $display("[TB] mispredicting branch stalled in M");
    applyStimulus(1, 0, 32'h0040_0300, 32'h0040_0400, 0, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(0, 0, 32'h0040_0304, 32'h0, 1, 0, 0, 0, 0, 0);
    clockEdge();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h0040_0308, 32'h0, 0, 1, 1, 0, 0, 0);
      checkOutput($sformatf("tp4_errorM_%0d", i), 64'(errorM), (i == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("tp4_branchM_%0d", i), 64'(branchM), 64'd1);
      clockEdge();
    end
    idleCycle();
    idleCycle();

    $display("[TB] M recovery collides with D prediction");
    applyStimulus(1, 0, 32'h0040_0500, 32'h0040_0600, 0, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(1, 0, 32'h0040_0504, 32'h0040_0700, 1, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(1, 1, 32'h0040_0508, 32'h0040_0800, 0, 1, 0, 1, 0, 0);
    checkOutput("tp5_pc_src", 64'(pc_src), 64'd2);
    checkOutput("tp5_redirect_pc", 64'(redirect_pc), 64'h0040_0600);
    clockEdge();
    idleCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp5_bubble_branchM", 64'(branchM), 64'd0);
    clockEdge();

`ifdef BRU_STATS_EN
    $display("[TB] statistics counters");
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    clockEdge();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 32'h0041_0000 + 32'(i * 16), 32'h0042_0000, 0, 0, 0, 0, 0, 0);
      clockEdge();
      applyStimulus(0, 0, 32'h0, 32'h0, (i < 2), 0, 0, 0, 0, 0);
      clockEdge();
    end
    repeat (3) idleCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("stats_branches5", 64'(stat_branches), 64'd5);
    checkOutput("stats_mispred2", 64'(stat_mispred), 64'd2);
    statClr = 1'b1;
    clockEdge();
    statClr = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("stats_clr_branches", 64'(stat_branches), 64'd0);
    checkOutput("stats_clr_mispred", 64'(stat_mispred), 64'd0);
    clockEdge();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 32'h0043_0000, 32'h0044_0000, 0, 0, 0, 0, 0, 0);
      clockEdge();
    end
    repeat (3) idleCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("stats_saturate", 64'(stat_branches), 64'd15);
    clockEdge();
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      statClr = ($urandom_range(0, 49) == 0);
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom(), $urandom(),
                    $urandom_range(0, 1), ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 199) == 0));
      clockEdge();
    end
    statClr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
    $finish;
  end

endmodule
